// File: rtl/aes_cbc_chain_ctrl.sv
// CBC chaining controller around a combinational AES-128 encrypt core: one block in flight at a time.
// Optional block counter output blk_cnt is compiled in when AES_CBC_BLKCNT_EN is defined.
module aes_cbc_chain_ctrl #(
    parameter int WAIT_CYC = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] iv_in,
    input  logic [127:0] key_in,
    input  logic         pt_valid,
    input  logic         pt_last,
    input  logic [127:0] pt_data,
    output logic         pt_ready,
    output logic         ct_valid,
    output logic         ct_last,
    output logic [127:0] ct_data,
    input  logic         ct_ready,
    output logic [127:0] core_in,
    output logic [127:0] core_iv,
    output logic [127:0] core_key,
    input  logic [127:0] core_out,
`ifdef AES_CBC_BLKCNT_EN
    output logic [31:0]  blk_cnt,
`endif
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC);

    state_t       state;
    logic [127:0] chain_reg;
    logic [127:0] key_reg;
    logic [127:0] pt_reg;
    logic [127:0] ct_reg;
    logic         last_reg;
    logic [3:0]   cnt;

    // The core sees only held registers, so its output is settled by the capture edge.
    assign core_in  = pt_reg;
    assign core_iv  = chain_reg;
    assign core_key = key_reg;
    assign ct_data  = ct_reg;
    assign ct_last  = last_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            chain_reg <= '0;
            key_reg   <= '0;
            pt_reg    <= '0;
            ct_reg    <= '0;
            last_reg  <= 1'b0;
            cnt       <= '0;
            pt_ready  <= 1'b0;
            ct_valid  <= 1'b0;
            busy      <= 1'b0;
`ifdef AES_CBC_BLKCNT_EN
            blk_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        chain_reg <= iv_in;
                        key_reg   <= key_in;
                        state     <= ACCEPT;
                        pt_ready  <= 1'b1;
                        busy      <= 1'b1;
`ifdef AES_CBC_BLKCNT_EN
                        blk_cnt   <= '0;
`endif
                    end
                end
                ACCEPT: begin
                    if (pt_valid) begin
                        pt_reg   <= pt_data;
                        last_reg <= pt_last;
                        cnt      <= 4'd1;
                        state    <= WAIT;
                        pt_ready <= 1'b0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == WAIT_LAST) begin
                        ct_reg   <= core_out;
                        state    <= HOLD;
                        ct_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (ct_ready) begin
                        chain_reg <= ct_reg;
                        ct_valid  <= 1'b0;
`ifdef AES_CBC_BLKCNT_EN
                        blk_cnt   <= blk_cnt + 32'd1;
`endif
                        if (last_reg) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state    <= ACCEPT;
                            pt_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    pt_ready <= 1'b0;
                    ct_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cbc_chain_ctrl.sv
// Bench for aes_cbc_chain_ctrl: behavioural AES-128 core, CBC reference model, directed and random messages.
// Define AES_CBC_BLKCNT_EN to also exercise the block counter.
module tb_aes_cbc_chain_ctrl;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst, start, pt_valid, pt_last, ct_ready;
    logic [127:0] iv_in, key_in, pt_data, core_out;
    logic         pt_ready, ct_valid, ct_last, busy;
    logic [127:0] ct_data, core_in, core_iv, core_key;
`ifdef AES_CBC_BLKCNT_EN
    logic [31:0]  blk_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_cbc_chain_ctrl #(.WAIT_CYC(W)) dut (
        .clk(clk), .rst(rst), .start(start), .iv_in(iv_in), .key_in(key_in),
        .pt_valid(pt_valid), .pt_last(pt_last), .pt_data(pt_data), .pt_ready(pt_ready),
        .ct_valid(ct_valid), .ct_last(ct_last), .ct_data(ct_data), .ct_ready(ct_ready),
        .core_in(core_in), .core_iv(core_iv), .core_key(core_key), .core_out(core_out),
`ifdef AES_CBC_BLKCNT_EN
        .blk_cnt(blk_cnt),
`endif
        .busy(busy)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    // S-box from first principles: multiplicative inverse (x^254) then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p, r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] blk);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3, rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox(s[i]);
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) s[r+4*c] = t[r+4*((c+r)%4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd+i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // The aes_enc_top stand-in: in is XORed with iv, then encrypted under key.
    always_comb core_out = aes128(core_key, core_in ^ core_iv);

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [127:0] key, input logic [127:0] iv);
        start = 1'b1; key_in = key; iv_in = iv;
        tick();
        start = 1'b0; key_in = rand128(); iv_in = rand128();
        chk("start_busy", busy, 1);
        chk("start_pt_ready", pt_ready, 1);
        chk("start_core_iv", core_iv, iv);
        chk("start_core_key", core_key, key);
    endtask

    // One block: accept, fixed-latency check, optional backpressure and start poke, then handshake.
    task automatic send(input logic [127:0] pt, input logic last, input int bp,
                        input logic poke, input logic [127:0] exp_ct, input logic [127:0] key);
        chk("pre_pt_ready", pt_ready, 1);
        pt_valid = 1'b1; pt_data = pt; pt_last = last;
        tick();
        pt_valid = 1'b0; pt_data = rand128(); pt_last = $urandom_range(0, 1);
        chk("acc_pt_ready", pt_ready, 0);
        chk("acc_core_in", core_in, pt);
        if (poke) begin
            start = 1'b1; iv_in = '0; key_in = '0;
        end
        for (int i = 0; i < W; i++) begin
            chk("early_ct_valid", ct_valid, 0);
            tick();
            start = 1'b0;
        end
        chk("lat_ct_valid", ct_valid, 1);
        chk("ct_data", ct_data, exp_ct);
        chk("ct_last", ct_last, last);
        chk("hold_core_key", core_key, key);
        for (int i = 0; i < bp; i++) begin
            tick();
            chk("bp_ct_data", ct_data, exp_ct);
            chk("bp_ct_valid", ct_valid, 1);
            chk("bp_pt_ready", pt_ready, 0);
        end
        ct_ready = 1'b1;
        tick();
        ct_ready = 1'b0;
        chk("hs_ct_valid", ct_valid, 0);
        chk("hs_chain", core_iv, exp_ct);
        chk("hs_pt_ready", pt_ready, !last);
        chk("hs_busy", busy, !last);
    endtask

    task automatic run_msg(input logic [127:0] key, input logic [127:0] iv, input logic [127:0] pts[$],
                           input logic [127:0] exps[$], input int bp, input logic poke);
        do_start(key, iv);
        for (int i = 0; i < pts.size(); i++)
            send(pts[i], i == pts.size() - 1, bp, poke, exps[i], key);
    endtask

    // CBC reference: each ciphertext is E_k(plaintext XOR previous ciphertext), seeded by the IV.
    function automatic void cbc_model(input logic [127:0] key, input logic [127:0] iv,
                                      input logic [127:0] pts[$], output logic [127:0] exps[$]);
        logic [127:0] prev;
        prev = iv;
        exps = {};
        foreach (pts[i]) begin
            prev = aes128(key, pts[i] ^ prev);
            exps.push_back(prev);
        end
    endfunction

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [127:0] k_v, iv_v, k_r, iv_r;
        logic [127:0] pts_v[$], exps_v[$], pts_r[$], exps_r[$];
        k_v    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        iv_v   = 128'h000102030405060708090a0b0c0d0e0f;
        pts_v  = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51};
        exps_v = '{128'h7649abac8119b246cee98e9b12e9197d, 128'h5086cb9b507219ee95db113a917678b2};

        rst = 1'b1; start = 1'b0; pt_valid = 1'b0; pt_last = 1'b0; ct_ready = 1'b0;
        iv_in = '0; key_in = '0; pt_data = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_pt_ready", pt_ready, 0);
        chk("rst_ct_valid", ct_valid, 0);
        chk("rst_ct_data", ct_data, 0);
        chk("rst_ct_last", ct_last, 0);
        chk("rst_core_in", core_in, 0);
        chk("rst_core_iv", core_iv, 0);
        chk("rst_core_key", core_key, 0);

        ct_ready = 1'b1; pt_valid = 1'b1; pt_data = rand128();
        tick(); tick();
        ct_ready = 1'b0; pt_valid = 1'b0;
        chk("idle_ignore_busy", busy, 0);
        chk("idle_ignore_core_in", core_in, 0);

        run_msg(k_v, iv_v, pts_v, exps_v, 0, 1'b0);
`ifdef AES_CBC_BLKCNT_EN
        chk("blk_cnt_two", blk_cnt, 2);
`endif
        tick();
        chk("idle_after_msg", busy, 0);

        do_start(k_v, iv_v);
`ifdef AES_CBC_BLKCNT_EN
        chk("blk_cnt_cleared", blk_cnt, 0);
`endif
        send(pts_v[0], 1'b0, 10, 1'b0, exps_v[0], k_v);
        send(pts_v[1], 1'b1, 10, 1'b0, exps_v[1], k_v);

        run_msg(k_v, iv_v, pts_v, exps_v, 1, 1'b1);

        do_start(k_v, iv_v);
        pt_valid = 1'b1; pt_data = pts_v[0]; pt_last = 1'b0;
        tick();
        pt_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_ct_valid", ct_valid, 0);
        chk("midrst_core_iv", core_iv, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_no_ct", ct_valid, 0);
            chk("midrst_pt_ready", pt_ready, 0);
        end
        run_msg(k_v, iv_v, pts_v, exps_v, 0, 1'b0);

        k_r = rand128(); iv_r = rand128();
        pts_r = '{rand128()};
        cbc_model(k_r, iv_r, pts_r, exps_r);
        run_msg(k_r, iv_r, pts_r, exps_r, 2, 1'b0);

        for (int m = 0; m < 4; m++) begin
            k_r = rand128(); iv_r = rand128();
            pts_r = {};
            for (int b = 0; b < int'($urandom_range(1, 4)); b++) pts_r.push_back(rand128());
            cbc_model(k_r, iv_r, pts_r, exps_r);
            run_msg(k_r, iv_r, pts_r, exps_r, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
`ifdef AES_CBC_BLKCNT_EN
            chk("blk_cnt_rand", blk_cnt, 32'(pts_r.size()));
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
